qspi_flash_sequencer: RTL and testbench
=======================================

# qspi_flash_sequencer

Command sequencer sitting between a simple client request port and `qspi_master`. Expands single client operations (READ, PROGRAM, SECTOR_ERASE) into the N25Q command sequences:

- Write-enable before any modifying command.
- Status-register polling until the flash clears WIP, with a bounded poll count.

It drives the master's command inputs and consumes its `o_busy`/`o_done`/`o_read_word` outputs.

## Interface
- `ADDR_W`, 24, flash address width
- `DATA_W`, 32, data word width (matches master `i_data`/`o_read_word`)
- `POLL_LIMIT`, 1024, max RDSR polls before timeout (≥1)
- `i_clk`  in  1  system clock (all logic on rising edge)
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_req`  in  1  client request, sampled only in IDLE
- `i_op`  in  2  00 READ, 01 PROGRAM, 10 SECTOR_ERASE, 11 illegal
- `i_addr`  in  ADDR_W  flash address
- `i_wdata`  in  DATA_W  program data
- `o_ack`  out  1  one-cycle pulse: request accepted
- `o_busy`  out  1  operation in progress
- `o_done`  out  1  one-cycle completion pulse
- `o_error`  out  1  valid with `o_done`: illegal op or poll timeout
- `o_rdata`  out  DATA_W  READ result, valid from `o_done`, held until next `o_ack`
- `o_m_command`  out  8  opcode to master
- `o_m_addr`  out  ADDR_W  address to master
- `o_m_data`  out  DATA_W  write data to master
- `o_m_rw`  out  1  1 = read transaction
- `o_m_enable`  out  1  one-cycle transaction start pulse
- `i_m_busy`  in  1  master busy
- `i_m_done`  in  1  master transaction-complete pulse
- `i_m_read_word`  in  DATA_W  master read data; status byte in [7:0], WIP = bit 0

## Operation
- Sequences per op:
  - READ: 0x03 (addr, rw=1).
  - PROGRAM: 0x06 → 0x02 (addr, data, rw=0) → poll.
  - SECTOR_ERASE: 0x06 → 0xD8 (addr) → poll.
- Poll step: 0x05 (rw=1). Repeat while WIP=1.
- States:
  - IDLE: `i_req` → latch op/addr/wdata, pulse `o_ack`, go to ISSUE. If op is illegal, go to FINISH with error instead.
  - ISSUE: when `i_m_busy`=0, pulse `o_m_enable` with command fields stable, then go to WAIT. Otherwise hold.
  - WAIT: on `i_m_done`, go to CHECK.
  - CHECK:
    - If the step was READ, capture `o_rdata`.
    - If the step was poll: WIP=0 → FINISH; WIP=1 and poll count < POLL_LIMIT → ISSUE (poll again); otherwise FINISH with error.
    - Any other step → advance step index, go to ISSUE.
  - FINISH: pulse `o_done` (with `o_error` if set), then go to IDLE.
- `i_req` outside IDLE is ignored (no queueing).
- `i_m_done` outside WAIT is ignored.
- Poll counter is ceil(log2(POLL_LIMIT+1)) bits, cleared at accept, incremented per poll issued. It never wraps.

## Timing
- Reset values: `o_ack`, `o_busy`, `o_done`, `o_error`, `o_m_enable`, `o_m_rw` = 0. `o_rdata`, `o_m_command`, `o_m_addr`, `o_m_data` = 0. State = IDLE.
- `o_ack` is asserted in the cycle after `i_req` is sampled high in IDLE. `o_busy` rises in the same cycle and falls in the cycle after `o_done`.
- `o_m_command`, `o_m_addr`, `o_m_data`, `o_m_rw` are registered. They are stable from the `o_m_enable` cycle until the next ISSUE.
- Minimum turnaround from `i_m_done` to the next `o_m_enable` is 2 cycles (CHECK, ISSUE).
- Illegal op: `o_done`+`o_error` 1 cycle after `o_ack`. Zero master transactions.
- Asynchronous reset mid-sequence returns to IDLE immediately and drops `o_m_enable`. The master shares `i_rst_n`, so there is no in-flight recovery.

## Structure
- Package `qspi_seq_pkg` holds:
  - opcode localparams: `CMD_WREN`=0x06, `CMD_PP`=0x02, `CMD_SE`=0xD8, `CMD_READ`=0x03, `CMD_RDSR`=0x05
  - `op_e`, `state_e`, `step_e` typedefs
- Single module, no sub-module. The step decode is a small case on (op, step).

## Test plan
- READ addr 0x000100 against a flash model preloaded with 0xA5A5_5A5A: exactly one master transaction (0x03, rw=1); `o_done` with `o_rdata`=0xA5A5_5A5A and `o_error`=0.
- PROGRAM addr 0x000200, data 0x1234_5678: transaction order 0x06, 0x02, then ≥1×0x05; `o_done` with `o_error`=0. A following READ returns 0x1234_5678.
- SECTOR_ERASE addr 0x010000 with a stub master holding WIP=1 for 3 polls: exactly 4 RDSR transactions, then `o_done` with no error.
- POLL_LIMIT=4 with WIP stuck at 1: exactly 4 RDSR transactions, then `o_done`+`o_error`=1.
- `i_op`=2'b11: `o_ack`, then `o_done`+`o_error` on the next cycle; `o_m_enable` never asserts. A second `i_req` while busy produces no `o_ack`.
- `i_rst_n` low during a PROGRAM WAIT: all outputs take their reset values immediately. A new READ after release completes normally.

Source files
------------

// File: rtl/qspi_seq_pkg.sv
// Shared types and N25Q opcodes for the QSPI flash command sequencer.
// Imported by qspi_flash_sequencer.
package qspi_seq_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    STEP_0    = 2'd0,
    STEP_1    = 2'd1,
    STEP_POLL = 2'd2
  } step_e;

endpackage

// File: rtl/qspi_flash_sequencer.sv
// Expands READ / PROGRAM / SECTOR_ERASE client requests into N25Q
// command sequences on the qspi_master command port.
module qspi_flash_sequencer
  import qspi_seq_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic [1:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [DATA_W-1:0] o_rdata,
  output logic [7:0]        o_m_command,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_rw,
  output logic              o_m_enable,
  input  logic              i_m_busy,
  input  logic              i_m_done,
  input  logic [DATA_W-1:0] i_m_read_word
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] LIMIT = PCW'(POLL_LIMIT);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  step_e             step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rword_q, rword_d;
  logic [PCW-1:0]    cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              rw_q, rw_d;
  logic              en_q, en_d;

  logic [7:0]        dec_cmd;
  logic              dec_rw;
  logic              wip;
  logic              is_poll;

  assign wip     = rword_q[0];
  assign is_poll = (step_q == STEP_POLL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      step_q  <= STEP_0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      cmd_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_req)
          state_d = (op_e'(i_op) == OP_ILL) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE:  if (!i_m_busy) state_d = S_WAIT;
      S_WAIT:   if (i_m_done) state_d = S_CHECK;
      S_CHECK: begin
        if (is_poll)
          state_d = (wip && cnt_q < LIMIT) ? S_ISSUE : S_FINISH;
        else
          state_d = (op_q == OP_READ) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dec_cmd = CMD_RDSR;
    dec_rw  = 1'b1;
    case ({op_q, step_q})
      {OP_READ, STEP_0}: dec_cmd = CMD_READ;
      {OP_PROG, STEP_0},
      {OP_ERASE, STEP_0}: begin
        dec_cmd = CMD_WREN;
        dec_rw  = 1'b0;
      end
      {OP_PROG, STEP_1}: begin
        dec_cmd = CMD_PP;
        dec_rw  = 1'b0;
      end
      {OP_ERASE, STEP_1}: begin
        dec_cmd = CMD_SE;
        dec_rw  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    step_d  = step_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    rw_d    = rw_q;
    en_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_req) begin
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          op_d    = op_e'(i_op);
          step_d  = STEP_0;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          cnt_d   = '0;
          err_d   = (op_e'(i_op) == OP_ILL);
        end
      end
      S_ISSUE: begin
        if (!i_m_busy) begin
          en_d    = 1'b1;
          cmd_d   = dec_cmd;
          rw_d    = dec_rw;
          maddr_d = addr_q;
          mdata_d = wdata_q;
          if (is_poll) cnt_d = cnt_q + PCW'(1);
        end
      end
      S_WAIT: if (i_m_done) rword_d = i_m_read_word;
      S_CHECK: begin
        if (is_poll) begin
          if (wip && cnt_q >= LIMIT) err_d = 1'b1;
        end else if (op_q == OP_READ) begin
          rdata_d = rword_q;
        end else begin
          step_d = (step_q == STEP_0) ? STEP_1 : STEP_POLL;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        error_d = err_q;
      end
      default: ;
    endcase
  end

  assign o_ack       = ack_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_rdata     = rdata_q;
  assign o_m_command = cmd_q;
  assign o_m_addr    = maddr_q;
  assign o_m_data    = mdata_q;
  assign o_m_rw      = rw_q;
  assign o_m_enable  = en_q;

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Directed bench for qspi_flash_sequencer with a behavioural master
// and flash stub; POLL_LIMIT is 4 so timeout paths stay short.
module tb_qspi_flash_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [1:0]  i_op;
  logic [23:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ack, o_busy, o_done, o_error;
  logic [31:0] o_rdata;
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  logic [31:0] m_data;
  logic        m_rw, m_en;
  logic        m_busy, m_done;
  logic [31:0] m_rword;

  int checks = 0;
  int errors = 0;

  logic [7:0]  log_q[$];
  logic [31:0] mem [logic [23:0]];
  int          wip_polls;
  bit          stuck;
  int          lat;

  always #5 clk = ~clk;

  qspi_flash_sequencer #(
    .ADDR_W(24), .DATA_W(32), .POLL_LIMIT(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(i_req), .i_op(i_op), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ack(o_ack), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_rdata(o_rdata),
    .o_m_command(m_cmd), .o_m_addr(m_addr), .o_m_data(m_data),
    .o_m_rw(m_rw), .o_m_enable(m_en),
    .i_m_busy(m_busy), .i_m_done(m_done), .i_m_read_word(m_rword)
  );

  // Master + flash stub: fixed 3-cycle transaction, WIP scripted per test.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_rword <= '0;
      lat     <= 0;
      mem[24'h000100] = 32'hA5A5_5A5A;
    end else begin
      m_done <= 1'b0;
      if (m_en && !m_busy) begin
        int n5;
        n5 = 0;
        foreach (log_q[k]) if (log_q[k] == 8'h05) n5++;
        log_q.push_back(m_cmd);
        m_busy <= 1'b1;
        lat    <= 2;
        case (m_cmd)
          8'h03:   m_rword <= mem.exists(m_addr) ? mem[m_addr] : 32'h0;
          8'h02:   mem[m_addr] = m_data;
          8'h05:   m_rword <= {31'b0, (stuck || n5 < wip_polls)};
          default: m_rword <= '0;
        endcase
      end else if (m_busy) begin
        if (lat == 0) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          wip;
    bit          stuck;
    int          n;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv[5];

  task automatic start(input logic [1:0] op, input logic [23:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    i_req   = 1'b1;
    i_op    = op;
    i_addr  = a;
    i_wdata = d;
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit got;
    int extra;
    tv[0] = '{2'b00, 24'h000100, 32'h0, 0, 1'b0, 1,
              8'h03, 8'h00, 1'b0, 32'hA5A5_5A5A};
    tv[1] = '{2'b01, 24'h000200, 32'h1234_5678, 1, 1'b0, 4,
              8'h06, 8'h02, 1'b0, 32'hA5A5_5A5A};
    tv[2] = '{2'b00, 24'h000200, 32'h0, 0, 1'b0, 1,
              8'h03, 8'h00, 1'b0, 32'h1234_5678};
    tv[3] = '{2'b10, 24'h010000, 32'h0, 3, 1'b0, 6,
              8'h06, 8'hD8, 1'b0, 32'h1234_5678};
    tv[4] = '{2'b01, 24'h000300, 32'hCAFE_F00D, 0, 1'b1, 6,
              8'h06, 8'h02, 1'b1, 32'h1234_5678};

    rst_n = 1'b0; i_req = 1'b0; i_op = '0; i_addr = '0; i_wdata = '0;
    wip_polls = 0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {o_ack, o_busy, o_done, o_error, m_en, m_rw}, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_cmd", {m_cmd, m_addr}, 0);
    chk("rst_mdata", m_data, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      log_q.delete();
      wip_polls = tv[v].wip;
      stuck     = tv[v].stuck;
      start(tv[v].op, tv[v].addr, tv[v].wdata);
      chk($sformatf("v%0d_ack", v), {o_ack, o_busy}, 2'b11);
      wait_done(got);
      chk($sformatf("v%0d_done", v), got, 1);
      chk($sformatf("v%0d_err", v), o_error, tv[v].err);
      chk($sformatf("v%0d_rdata", v), o_rdata, tv[v].rdata);
      @(negedge clk);
      chk($sformatf("v%0d_busy_low", v), o_busy, 0);
      chk($sformatf("v%0d_ntxn", v), log_q.size(), tv[v].n);
      foreach (log_q[i])
        chk($sformatf("v%0d_cmd%0d", v, i), log_q[i],
            (i == 0) ? tv[v].c0 : (i == 1) ? tv[v].c1 : 8'h05);
    end

    // Illegal op: done+error right after ack, no master traffic
    log_q.delete();
    start(2'b11, 24'h0, 32'h0);
    chk("ill_ack", o_ack, 1);
    @(negedge clk);
    chk("ill_done_err", {o_done, o_error}, 2'b11);
    @(negedge clk);
    chk("ill_busy_low", o_busy, 0);
    chk("ill_ntxn", log_q.size(), 0);

    // Requests while busy are dropped
    log_q.delete();
    stuck = 1'b0;
    start(2'b00, 24'h000100, 32'h0);
    chk("bz_ack", o_ack, 1);
    i_req = 1'b1;
    i_op  = 2'b01;
    extra = 0;
    got   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_ack) extra++;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    i_req = 1'b0;
    chk("bz_done", got, 1);
    chk("bz_no_ack", extra, 0);
    chk("bz_rdata", o_rdata, 32'hA5A5_5A5A);
    chk("bz_ntxn", log_q.size(), 1);
    @(negedge clk);

    // Reset while PROGRAM's page-program is in flight
    log_q.delete();
    wip_polls = 1;
    start(2'b01, 24'h000400, 32'hDEAD_BEEF);
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (log_q.size() == 2 && m_busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("rr_in_wait", got, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_outs", {o_ack, o_busy, o_done, o_error, m_en, m_rw}, 0);
    chk("rr_rdata", o_rdata, 0);
    chk("rr_cmd", {m_cmd, m_addr}, 0);
    chk("rr_mdata", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    start(2'b00, 24'h000100, 32'h0);
    chk("rr_ack", o_ack, 1);
    wait_done(got);
    chk("rr_done", got, 1);
    chk("rr_err", o_error, 0);
    chk("rr_read", o_rdata, 32'hA5A5_5A5A);
    chk("rr_ntxn", log_q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
